// File: rtl/imem_serial_loader.sv
// Boot-time loader: deserialises MSB-first instruction words into I_MEMORY,
// then enables the CPU and issues its start pulse.
//
// state | meaning
// IDLE  | no session yet; I_MEMORY address follows the CPU
// SHIFT | collecting serial bits and writing completed words at waddr
// ARM   | CPU enabled, counting down to the start pulse
// RUN   | program loaded and started; CPU owns I_MEMORY
module imem_serial_loader #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                START_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic              sdi,
  input  logic              sdi_valid,
  input  logic [ADDR_W-1:0] cpu_i_addr,
  output logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_we,
  output logic [DATA_W-1:0] i_wdata,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int DLY_W = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ARM   = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bitcnt;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] waddr;
  logic [DLY_W-1:0]  dly;

  logic [DATA_W-1:0] shreg_nxt;
  logic              word_done;
  logic              last_write;

  assign shreg_nxt  = {shreg[DATA_W-2:0], sdi};
  assign word_done  = sdi_valid && (bitcnt == BIT_W'(DATA_W - 1));
  assign last_write = i_we && ((wcnt + ADDR_W'(1)) == len);

  assign i_mem_addr = (state == S_SHIFT) ? waddr : cpu_i_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      len        <= '0;
      wcnt       <= '0;
      waddr      <= '0;
      dly        <= '0;
      i_we       <= 1'b0;
      i_wdata    <= '0;
      cpu_enable <= 1'b0;
      cpu_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      i_we      <= 1'b0;
      cpu_start <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (load_start) begin
            done <= 1'b0;
            busy <= 1'b1;
            if (prog_len != '0) begin
              state      <= S_SHIFT;
              len        <= prog_len;
              waddr      <= BASE_ADDR;
              wcnt       <= '0;
              cpu_enable <= 1'b0;
            end else begin
              state      <= S_ARM;
              cpu_enable <= 1'b1;
              dly        <= DLY_W'(START_DELAY);
            end
          end
        end
        S_SHIFT: begin
          if (i_we) begin
            waddr <= waddr + ADDR_W'(1);
            wcnt  <= wcnt + ADDR_W'(1);
          end
          // The final write cycle closes the session, so its serial bit is dropped.
          if (last_write) begin
            state      <= S_ARM;
            cpu_enable <= 1'b1;
            dly        <= DLY_W'(START_DELAY);
          end else if (sdi_valid) begin
            shreg <= shreg_nxt;
            if (word_done) begin
              i_wdata <= shreg_nxt;
              i_we    <= 1'b1;
              bitcnt  <= '0;
            end else begin
              bitcnt <= bitcnt + BIT_W'(1);
            end
          end
        end
        S_ARM: begin
          if (cpu_start) begin
            state <= S_RUN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            if (dly == DLY_W'(1)) cpu_start <= 1'b1;
            dly <= dly - DLY_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_serial_loader.sv
// Directed bench for imem_serial_loader: serial loads, start sequencing,
// reset behaviour, and a tiny behavioural CPU executing the loaded program.
module tb_imem_serial_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  prog_len;
  logic        sdi;
  logic        sdi_valid;
  logic [7:0]  cpu_i_addr;

  logic [7:0]  i_mem_addr,  fe_i_mem_addr;
  logic        i_we,        fe_i_we;
  logic [15:0] i_wdata,     fe_i_wdata;
  logic        cpu_enable,  fe_cpu_enable;
  logic        cpu_start,   fe_cpu_start;
  logic        busy,        fe_busy;
  logic        done,        fe_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] iram [256];
  logic [15:0] dram [256];
  logic [7:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  logic [7:0]  fe_addr[$];
  logic [15:0] fe_data[$];

  always #5 clk = ~clk;

  imem_serial_loader #(.ADDR_W(8), .DATA_W(16), .BASE_ADDR(8'h00), .START_DELAY(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .prog_len(prog_len),
    .sdi(sdi), .sdi_valid(sdi_valid), .cpu_i_addr(cpu_i_addr),
    .i_mem_addr(i_mem_addr), .i_we(i_we), .i_wdata(i_wdata),
    .cpu_enable(cpu_enable), .cpu_start(cpu_start), .busy(busy), .done(done)
  );

  imem_serial_loader #(.ADDR_W(8), .DATA_W(16), .BASE_ADDR(8'hFE), .START_DELAY(1)) dut_fe (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .prog_len(prog_len),
    .sdi(sdi), .sdi_valid(sdi_valid), .cpu_i_addr(cpu_i_addr),
    .i_mem_addr(fe_i_mem_addr), .i_we(fe_i_we), .i_wdata(fe_i_wdata),
    .cpu_enable(fe_cpu_enable), .cpu_start(fe_cpu_start), .busy(fe_busy), .done(fe_done)
  );

  always @(posedge clk) begin
    if (i_we) begin
      iram[i_mem_addr] <= i_wdata;
      wr_addr.push_back(i_mem_addr);
      wr_data.push_back(i_wdata);
    end
    if (fe_i_we) begin
      fe_addr.push_back(fe_i_mem_addr);
      fe_data.push_back(fe_i_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("start_needs_enable", {31'd0, cpu_start & ~cpu_enable}, 32'd0);
      chk("we_only_when_busy",  {31'd0, i_we & ~busy}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    step();
    wr_addr.delete();
    wr_data.delete();
    fe_addr.delete();
    fe_data.delete();
  endtask

  task automatic start_load(input logic [7:0] len);
    load_start = 1'b1;
    prog_len   = len;
    step();
    load_start = 1'b0;
  endtask

  // Shifts w[nbits-1:0] MSB first; gap idle cycles (with sdi toggling) precede each bit.
  task automatic shift_bits(input logic [15:0] w, input int nbits, input int gap);
    for (int i = nbits - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        sdi_valid = 1'b0;
        sdi       = ~sdi;
        step();
      end
      sdi       = w[i];
      sdi_valid = 1'b1;
      step();
    end
    sdi_valid = 1'b0;
  endtask

  logic [15:0] prog [7];
  logic [15:0] rf   [16];
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        halted;
  int          waited;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; load_start = 1'b0; prog_len = '0;
    sdi = 1'b0; sdi_valid = 1'b0; cpu_i_addr = 8'h5A;
    for (int i = 0; i < 256; i++) begin iram[i] = '0; dram[i] = '0; end
    #2;
    chk("rst_we",     {31'd0, i_we}, 0);
    chk("rst_wdata",  {16'd0, i_wdata}, 0);
    chk("rst_enable", {31'd0, cpu_enable}, 0);
    chk("rst_start",  {31'd0, cpu_start}, 0);
    chk("rst_busy",   {31'd0, busy}, 0);
    chk("rst_done",   {31'd0, done}, 0);
    chk("idle_mux",   {24'd0, i_mem_addr}, 32'h5A);
    step();
    rst_n = 1'b1;
    step();

    // Two-word load, back-to-back bits.
    start_load(8'd2);
    chk("shift_busy", {31'd0, busy}, 1);
    chk("shift_mux",  {24'd0, i_mem_addr}, 32'h00);
    shift_bits(16'h1234, 16, 0);
    chk("w0_we",   {31'd0, i_we}, 1);
    chk("w0_addr", {24'd0, i_mem_addr}, 32'h00);
    chk("w0_data", {16'd0, i_wdata}, 32'h1234);
    shift_bits(16'hABCD, 16, 0);
    chk("w1_we",   {31'd0, i_we}, 1);
    chk("w1_addr", {24'd0, i_mem_addr}, 32'h01);
    chk("w1_data", {16'd0, i_wdata}, 32'hABCD);
    step();
    chk("arm_enable", {31'd0, cpu_enable}, 1);
    chk("arm_start0", {31'd0, cpu_start}, 0);
    chk("arm_we",     {31'd0, i_we}, 0);
    chk("arm_mux",    {24'd0, i_mem_addr}, 32'h5A);
    step();
    chk("start_pulse", {31'd0, cpu_start}, 1);
    chk("start_done0", {31'd0, done}, 0);
    step();
    chk("run_start0", {31'd0, cpu_start}, 0);
    chk("run_done",   {31'd0, done}, 1);
    chk("run_busy",   {31'd0, busy}, 0);
    chk("run_enable", {31'd0, cpu_enable}, 1);
    chk("two_writes", wr_addr.size(), 2);
    chk("iram0", {16'd0, iram[0]}, 32'h1234);
    chk("iram1", {16'd0, iram[1]}, 32'hABCD);

    // prog_len = 0: no load, just start.
    do_reset();
    start_load(8'd0);
    chk("len0_enable", {31'd0, cpu_enable}, 1);
    chk("len0_start0", {31'd0, cpu_start}, 0);
    step();
    chk("len0_start", {31'd0, cpu_start}, 1);
    step();
    chk("len0_done",   {31'd0, done}, 1);
    chk("len0_nowrite", wr_addr.size(), 0);

    // Gapped strobes with sdi toggling in invalid cycles.
    do_reset();
    start_load(8'd1);
    shift_bits(16'h00F0, 16, 2);
    chk("gap_we",   {31'd0, i_we}, 1);
    chk("gap_data", {16'd0, i_wdata}, 32'h00F0);
    step();
    chk("gap_count",  wr_addr.size(), 1);
    chk("gap_enable", {31'd0, cpu_enable}, 1);

    // Reset mid-load.
    do_reset();
    start_load(8'd2);
    shift_bits(16'hFFFF, 8, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'd0, busy}, 0);
    chk("mid_rst_we",     {31'd0, i_we}, 0);
    chk("mid_rst_enable", {31'd0, cpu_enable}, 0);
    chk("mid_rst_wdata",  {16'd0, i_wdata}, 0);
    chk("mid_rst_nowrite", wr_addr.size(), 0);
    step();
    rst_n = 1'b1;
    step();
    start_load(8'd1);
    shift_bits(16'hC3A5, 16, 0);
    chk("fresh_addr", {24'd0, i_mem_addr}, 32'h00);
    chk("fresh_data", {16'd0, i_wdata}, 32'hC3A5);
    step();
    chk("fresh_count", wr_addr.size(), 1);

    // load_start ignored in SHIFT, honoured in RUN (BASE_ADDR=0xFE instance wraps).
    do_reset();
    start_load(8'd1);
    shift_bits(16'h0011, 8, 0);
    start_load(8'd9);
    chk("ign_busy",   {31'd0, busy}, 1);
    chk("ign_mux",    {24'd0, i_mem_addr}, 32'h00);
    chk("ign_fe_mux", {24'd0, fe_i_mem_addr}, 32'hFE);
    shift_bits(16'h0011, 8, 0);
    chk("ign_data", {16'd0, i_wdata}, 32'h1111);
    step();
    chk("ign_len_kept", {31'd0, cpu_enable}, 1);
    step();
    step();
    chk("ign_run", {31'd0, fe_done}, 1);
    fe_addr.delete();
    fe_data.delete();
    start_load(8'd3);
    chk("reload_enable", {31'd0, fe_cpu_enable}, 0);
    chk("reload_done",   {31'd0, fe_done}, 0);
    chk("reload_busy",   {31'd0, fe_busy}, 1);
    shift_bits(16'h0A0A, 16, 0);
    shift_bits(16'h0B0B, 16, 0);
    shift_bits(16'h0C0C, 16, 0);
    step();
    chk("wrap_count", fe_addr.size(), 3);
    if (fe_addr.size() == 3) begin
      chk("wrap_a0", {24'd0, fe_addr[0]}, 32'hFE);
      chk("wrap_a1", {24'd0, fe_addr[1]}, 32'hFF);
      chk("wrap_a2", {24'd0, fe_addr[2]}, 32'h00);
      chk("wrap_d2", {16'd0, fe_data[2]}, 32'h0C0C);
    end

    // Sum-loop program: r0 = 4+3+2+1, stored to D_RAM[2].
    prog[0] = 16'h1000;  // SET  r0, 0
    prog[1] = 16'h1104;  // SET  r1, 4
    prog[2] = 16'h2010;  // ADD  r0, r1
    prog[3] = 16'h3101;  // SUBI r1, 1
    prog[4] = 16'h4102;  // BNZ  r1, 2
    prog[5] = 16'h5002;  // STORE r0, [2]
    prog[6] = 16'hF000;  // HALT
    do_reset();
    start_load(8'd7);
    for (int k = 0; k < 7; k++) shift_bits(prog[k], 16, 0);
    waited = 0;
    while (done !== 1'b1 && waited < 20) begin step(); waited++; end
    chk("prog_done", {31'd0, done}, 1);
    for (int r = 0; r < 16; r++) rf[r] = '0;
    pc = '0;
    halted = 1'b0;
    for (int cyc = 0; cyc < 200 && !halted; cyc++) begin
      cpu_i_addr = pc;
      #1;
      chk("fetch_mux", {24'd0, i_mem_addr}, {24'd0, pc});
      instr = iram[i_mem_addr];
      case (instr[15:12])
        4'h1: begin rf[instr[11:8]] = {8'd0, instr[7:0]}; pc = pc + 1; end
        4'h2: begin rf[instr[11:8]] = rf[instr[11:8]] + rf[instr[7:4]]; pc = pc + 1; end
        4'h3: begin rf[instr[11:8]] = rf[instr[11:8]] - {8'd0, instr[7:0]}; pc = pc + 1; end
        4'h4: pc = (rf[instr[11:8]] != 0) ? instr[7:0] : pc + 1;
        4'h5: begin dram[instr[7:0]] = rf[instr[11:8]]; pc = pc + 1; end
        4'hF: halted = 1'b1;
        default: pc = pc + 1;
      endcase
      step();
    end
    chk("halt_reached", {31'd0, halted}, 1);
    chk("dram2", {16'd0, dram[2]}, 32'h000A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
